// File: rtl/ara_pkg.sv
// Shared lane types: instruction IDs, element words and write-back source tags.
package ara_pkg;

    localparam int unsigned NrVInsnDefault = 8;
    localparam int unsigned ELEN           = 64;

    typedef logic [$clog2(NrVInsnDefault)-1:0] vid_t;
    typedef logic [ELEN-1:0]                   elen_t;

    typedef enum logic {
        WbSrcAlu  = 1'b0,
        WbSrcMfpu = 1'b1
    } wb_src_e;

endpackage

// File: rtl/vfu_wb_arbiter_if.sv
// Result-stream and VRF write-port bundle around the shared write-back arbiter.
interface vfu_wb_arbiter_if #(
    parameter int unsigned NrVInsn   = 8,
    parameter int unsigned DataWidth = 64,
    parameter type         vaddr_t   = logic
);
    localparam int unsigned IdWidth   = (NrVInsn > 1) ? $clog2(NrVInsn) : 1;
    localparam int unsigned StrbWidth = DataWidth / 8;

    logic                 alu_req_i;
    logic [IdWidth-1:0]   alu_id_i;
    vaddr_t               alu_addr_i;
    logic [DataWidth-1:0] alu_wdata_i;
    logic [StrbWidth-1:0] alu_be_i;
    logic                 alu_gnt_o;

    logic                 mfpu_req_i;
    logic [IdWidth-1:0]   mfpu_id_i;
    vaddr_t               mfpu_addr_i;
    logic [DataWidth-1:0] mfpu_wdata_i;
    logic [StrbWidth-1:0] mfpu_be_i;
    logic                 mfpu_gnt_o;

    logic                 vrf_req_o;
    logic [IdWidth-1:0]   vrf_id_o;
    vaddr_t               vrf_addr_o;
    logic [DataWidth-1:0] vrf_wdata_o;
    logic [StrbWidth-1:0] vrf_be_o;
    logic                 vrf_src_o;
    logic                 vrf_gnt_i;

    logic                 alu_pending_o;
    logic                 mfpu_pending_o;

    modport slave (
        input  alu_req_i, alu_id_i, alu_addr_i, alu_wdata_i, alu_be_i,
        input  mfpu_req_i, mfpu_id_i, mfpu_addr_i, mfpu_wdata_i, mfpu_be_i,
        input  vrf_gnt_i,
        output alu_gnt_o, mfpu_gnt_o,
        output vrf_req_o, vrf_id_o, vrf_addr_o, vrf_wdata_o, vrf_be_o, vrf_src_o,
        output alu_pending_o, mfpu_pending_o
    );

    modport master (
        output alu_req_i, alu_id_i, alu_addr_i, alu_wdata_i, alu_be_i,
        output mfpu_req_i, mfpu_id_i, mfpu_addr_i, mfpu_wdata_i, mfpu_be_i,
        output vrf_gnt_i,
        input  alu_gnt_o, mfpu_gnt_o,
        input  vrf_req_o, vrf_id_o, vrf_addr_o, vrf_wdata_o, vrf_be_o, vrf_src_o,
        input  alu_pending_o, mfpu_pending_o
    );

endinterface

// File: rtl/vfu_wb_arbiter_src_buffer.sv
// One-entry result holding buffer; accepts a new word whenever empty or draining.
module wb_src_buffer #(
    parameter type payload_t = logic
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  logic     req_i,
    input  payload_t payload_i,
    input  logic     pop_i,
    output logic     gnt_o,
    output logic     valid_o,
    output payload_t payload_o
);

    logic     valid_q, valid_d;
    payload_t payload_q, payload_d;

    always_comb begin
        gnt_o     = req_i & (~valid_q | pop_i);
        valid_d   = valid_q;
        payload_d = payload_q;
        if (pop_i) valid_d = 1'b0;
        // Refill wins over pop so a draining buffer keeps streaming.
        if (gnt_o) begin
            valid_d   = 1'b1;
            payload_d = payload_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q   <= 1'b0;
            payload_q <= '0;
        end else begin
            valid_q   <= valid_d;
            payload_q <= payload_d;
        end
    end

    assign valid_o   = valid_q;
    assign payload_o = payload_q;

endmodule

// File: rtl/vfu_wb_arbiter.sv
// Round-robin share of one VRF write port between the ALU and MFPU result streams.
module vfu_wb_arbiter
    import ara_pkg::*;
#(
    parameter int unsigned NrVInsn   = 8,
    parameter int unsigned DataWidth = 64,
    parameter type         vaddr_t   = logic
) (
    input logic             clk_i,
    input logic             rst_i,
    vfu_wb_arbiter_if.slave bus
);

    localparam int unsigned IdWidth   = (NrVInsn > 1) ? $clog2(NrVInsn) : 1;
    localparam int unsigned StrbWidth = DataWidth / 8;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        vaddr_t               addr;
        logic [DataWidth-1:0] wdata;
        logic [StrbWidth-1:0] be;
    } payload_t;

    payload_t [1:0] src_pl, buf_pl;
    logic     [1:0] src_req, src_gnt, buf_vld, pop;
    logic           vrf_req;
    wb_src_e        sel;
    wb_src_e        ptr_q, ptr_d, lock_src_q, lock_src_d;
    logic           lock_q, lock_d;

    // Grants are held low during reset so nothing is accepted into cleared buffers.
    always_comb begin
        src_req[WbSrcAlu]  = bus.alu_req_i & ~rst_i;
        src_req[WbSrcMfpu] = bus.mfpu_req_i & ~rst_i;
        src_pl[WbSrcAlu]   = '{id: bus.alu_id_i, addr: bus.alu_addr_i,
                               wdata: bus.alu_wdata_i, be: bus.alu_be_i};
        src_pl[WbSrcMfpu]  = '{id: bus.mfpu_id_i, addr: bus.mfpu_addr_i,
                               wdata: bus.mfpu_wdata_i, be: bus.mfpu_be_i};
    end

    for (genvar i = 0; i < 2; i++) begin : g_buf
        wb_src_buffer #(.payload_t(payload_t)) i_buf (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .req_i    (src_req[i]),
            .payload_i(src_pl[i]),
            .pop_i    (pop[i]),
            .gnt_o    (src_gnt[i]),
            .valid_o  (buf_vld[i]),
            .payload_o(buf_pl[i])
        );
    end

    always_comb begin
        vrf_req = |buf_vld;
        if (lock_q)                                         sel = lock_src_q;
        else if (buf_vld[WbSrcAlu] & ~buf_vld[WbSrcMfpu])   sel = WbSrcAlu;
        else if (buf_vld[WbSrcMfpu] & ~buf_vld[WbSrcAlu])   sel = WbSrcMfpu;
        else                                                sel = ptr_q;
        pop = '0;
        if (vrf_req & bus.vrf_gnt_i) pop[sel] = 1'b1;
    end

    always_comb begin
        ptr_d = ptr_q;
        if (vrf_req & bus.vrf_gnt_i) ptr_d = (sel == WbSrcAlu) ? WbSrcMfpu : WbSrcAlu;
        // A presented but ungranted word pins the selection until it is written.
        lock_d     = vrf_req & ~bus.vrf_gnt_i;
        lock_src_d = sel;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q      <= WbSrcAlu;
            lock_q     <= 1'b0;
            lock_src_q <= WbSrcAlu;
        end else begin
            ptr_q      <= ptr_d;
            lock_q     <= lock_d;
            lock_src_q <= lock_src_d;
        end
    end

    payload_t out_pl;
    assign out_pl = vrf_req ? buf_pl[sel] : '0;

    assign bus.alu_gnt_o      = src_gnt[WbSrcAlu];
    assign bus.mfpu_gnt_o     = src_gnt[WbSrcMfpu];
    assign bus.vrf_req_o      = vrf_req;
    assign bus.vrf_src_o      = vrf_req & (sel == WbSrcMfpu);
    assign bus.vrf_id_o       = out_pl.id;
    assign bus.vrf_addr_o     = out_pl.addr;
    assign bus.vrf_wdata_o    = out_pl.wdata;
    assign bus.vrf_be_o       = out_pl.be;
    assign bus.alu_pending_o  = buf_vld[WbSrcAlu];
    assign bus.mfpu_pending_o = buf_vld[WbSrcMfpu];

endmodule

// File: tb/tb_vfu_wb_arbiter.sv
// Directed and scoreboarded random checks of the shared VRF write-back arbiter.
module tb_vfu_wb_arbiter;

    logic clk, rst;
    int   checks = 0;
    int   errors = 0;

    vfu_wb_arbiter_if #(.NrVInsn(8), .DataWidth(64), .vaddr_t(logic [15:0])) bus ();

    vfu_wb_arbiter #(.NrVInsn(8), .DataWidth(64), .vaddr_t(logic [15:0])) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive_alu(input logic r, input logic [2:0] id, input logic [15:0] a,
                             input logic [63:0] d, input logic [7:0] be);
        bus.alu_req_i = r; bus.alu_id_i = id; bus.alu_addr_i = a;
        bus.alu_wdata_i = d; bus.alu_be_i = be;
    endtask

    task automatic drive_mfpu(input logic r, input logic [2:0] id, input logic [15:0] a,
                              input logic [63:0] d, input logic [7:0] be);
        bus.mfpu_req_i = r; bus.mfpu_id_i = id; bus.mfpu_addr_i = a;
        bus.mfpu_wdata_i = d; bus.mfpu_be_i = be;
    endtask

    logic [90:0] qa[$];
    logic [90:0] qm[$];
    int          wait_a = 0;
    int          wait_m = 0;

    function automatic logic [90:0] vrf_pl();
        return {bus.vrf_id_o, bus.vrf_addr_o, bus.vrf_wdata_o, bus.vrf_be_o};
    endfunction

    // One cycle of random traffic with scoreboard and starvation tracking.
    task automatic rnd_cycle(input bit active);
        logic        ag, mg, pa, pm;
        logic [90:0] pl, exp_pl;
        drive_alu(active && ($urandom_range(0, 2) != 0), 3'($urandom), 16'($urandom),
                  {$urandom, $urandom}, 8'($urandom));
        drive_mfpu(active && ($urandom_range(0, 2) != 0), 3'($urandom), 16'($urandom),
                   {$urandom, $urandom}, 8'($urandom));
        bus.vrf_gnt_i = active ? ($urandom_range(0, 3) != 0) : 1'b1;
        #1;
        ag = bus.alu_gnt_o; mg = bus.mfpu_gnt_o;
        pa = bus.alu_pending_o; pm = bus.mfpu_pending_o;
        if (bus.vrf_req_o && bus.vrf_gnt_i) begin
            pl = vrf_pl();
            if (bus.vrf_src_o == 1'b0) begin
                if (qa.size() == 0) chk("rnd_alu_q_nonempty", qa.size(), 1);
                else begin exp_pl = qa.pop_front(); chk("rnd_alu_order", pl, exp_pl); end
                wait_a = 0;
                if (pm) begin wait_m++; chk("rnd_mfpu_starve", wait_m <= 2, 1); end
            end else begin
                if (qm.size() == 0) chk("rnd_mfpu_q_nonempty", qm.size(), 1);
                else begin exp_pl = qm.pop_front(); chk("rnd_mfpu_order", pl, exp_pl); end
                wait_m = 0;
                if (pa) begin wait_a++; chk("rnd_alu_starve", wait_a <= 2, 1); end
            end
        end
        if (ag) qa.push_back({bus.alu_id_i, bus.alu_addr_i, bus.alu_wdata_i, bus.alu_be_i});
        if (mg) qm.push_back({bus.mfpu_id_i, bus.mfpu_addr_i, bus.mfpu_wdata_i, bus.mfpu_be_i});
        tick();
    endtask

    logic [64:0] got[16];
    int          n, ai, mi;
    logic        ag, mg;

    initial begin
        rst = 1'b1;
        drive_alu(1'b1, 3'd0, 16'h0, 64'h0, 8'h0);
        drive_mfpu(1'b0, 3'd0, 16'h0, 64'h0, 8'h0);
        bus.vrf_gnt_i = 1'b0;
        #1;
        chk("rst_vrf_req", bus.vrf_req_o, 0);
        chk("rst_alu_gnt", bus.alu_gnt_o, 0);
        chk("rst_pending", {bus.alu_pending_o, bus.mfpu_pending_o}, 0);
        chk("rst_wdata", bus.vrf_wdata_o, 0);
        bus.alu_req_i = 1'b0;
        @(posedge clk); @(negedge clk); rst = 1'b0;
        tick();

        // Single ALU word, 1-cycle latency.
        bus.vrf_gnt_i = 1'b1;
        drive_alu(1'b1, 3'd3, 16'h0010, 64'hDEAD_BEEF, 8'hFF);
        #1;
        chk("t1_alu_gnt", bus.alu_gnt_o, 1);
        chk("t1_no_req_yet", bus.vrf_req_o, 0);
        tick();
        bus.alu_req_i = 1'b0;
        #1;
        chk("t1_vrf_req", bus.vrf_req_o, 1);
        chk("t1_payload", vrf_pl(), {3'd3, 16'h0010, 64'hDEAD_BEEF, 8'hFF});
        chk("t1_src", bus.vrf_src_o, 0);
        tick();
        #1;
        chk("t1_empty", bus.alu_pending_o, 0);
        chk("t1_idle_payload", vrf_pl(), 0);

        // Single MFPU word returns the pointer to ALU.
        drive_mfpu(1'b1, 3'd5, 16'h0020, 64'h1234, 8'h0F);
        tick();
        bus.mfpu_req_i = 1'b0;
        #1;
        chk("t1m_src", bus.vrf_src_o, 1);
        chk("t1m_payload", vrf_pl(), {3'd5, 16'h0020, 64'h1234, 8'h0F});
        tick();

        // Both sources stream four words: ALU0, MFPU0, ALU1, MFPU1, ...
        n = 0; ai = 0; mi = 0;
        for (int c = 0; c < 20; c++) begin
            drive_alu(ai < 4, 3'd1, 16'h0100, 64'hA0 + 64'(ai), 8'hFF);
            drive_mfpu(mi < 4, 3'd2, 16'h0200, 64'hB0 + 64'(mi), 8'hFF);
            #1;
            if (bus.vrf_req_o && n < 16) begin
                got[n] = {bus.vrf_src_o, bus.vrf_wdata_o};
                n++;
            end
            ag = bus.alu_gnt_o; mg = bus.mfpu_gnt_o;
            tick();
            if (ag) ai++;
            if (mg) mi++;
        end
        chk("t2_count", n, 8);
        for (int i = 0; i < 8; i++)
            chk($sformatf("t2_word%0d", i), got[i],
                (i % 2 == 0) ? {1'b0, 64'hA0 + 64'(i / 2)} : {1'b1, 64'hB0 + 64'(i / 2)});

        // Single ALU pop moves the pointer to MFPU; the lock must still keep ALU.
        drive_alu(1'b1, 3'd1, 16'h0300, 64'h30, 8'hFF);
        tick();
        bus.alu_req_i = 1'b0;
        #1;
        chk("t3_prefix", bus.vrf_wdata_o, 64'h30);
        tick();
        bus.vrf_gnt_i = 1'b0;
        drive_alu(1'b1, 3'd1, 16'h0300, 64'h31, 8'hFF);
        #1;
        chk("t3_fill_alu", bus.alu_gnt_o, 1);
        tick();
        drive_alu(1'b1, 3'd1, 16'h0300, 64'h32, 8'hFF);
        drive_mfpu(1'b1, 3'd2, 16'h0400, 64'h41, 8'hFF);
        #1;
        chk("t3_alu_presented", {bus.vrf_req_o, bus.vrf_src_o}, 2'b10);
        chk("t3_fill_mfpu", bus.mfpu_gnt_o, 1);
        tick();
        drive_mfpu(1'b1, 3'd2, 16'h0400, 64'h42, 8'hFF);
        for (int c = 0; c < 5; c++) begin
            #1;
            chk($sformatf("t3_stall_req%0d", c), {bus.vrf_req_o, bus.vrf_src_o}, 2'b10);
            chk($sformatf("t3_stall_data%0d", c), bus.vrf_wdata_o, 64'h31);
            chk($sformatf("t3_stall_gnts%0d", c), {bus.alu_gnt_o, bus.mfpu_gnt_o}, 0);
            tick();
        end
        bus.vrf_gnt_i = 1'b1;
        #1;
        chk("t3_rel_data", {bus.vrf_src_o, bus.vrf_wdata_o}, {1'b0, 64'h31});
        chk("t3_rel_gnts", {bus.alu_gnt_o, bus.mfpu_gnt_o}, 2'b10);
        tick();
        bus.alu_req_i = 1'b0;
        #1;
        chk("t3_second", {bus.vrf_src_o, bus.vrf_wdata_o}, {1'b1, 64'h41});
        chk("t3_mfpu_refill", bus.mfpu_gnt_o, 1);
        tick();
        bus.mfpu_req_i = 1'b0;
        #1;
        chk("t3_third", {bus.vrf_src_o, bus.vrf_wdata_o}, {1'b0, 64'h32});
        tick();
        #1;
        chk("t3_fourth", {bus.vrf_src_o, bus.vrf_wdata_o}, {1'b1, 64'h42});
        tick();
        #1;
        chk("t3_idle", bus.vrf_req_o, 0);

        // MFPU streams one word per cycle.
        for (int k = 0; k < 6; k++) begin
            drive_mfpu(1'b1, 3'd4, 16'h0500, 64'hC0 + 64'(k), 8'hFF);
            #1;
            chk($sformatf("t4_gnt%0d", k), bus.mfpu_gnt_o, 1);
            if (k > 0)
                chk($sformatf("t4_out%0d", k), {bus.vrf_req_o, bus.vrf_src_o, bus.vrf_wdata_o},
                    {2'b11, 64'hC0 + 64'(k - 1)});
            tick();
        end
        bus.mfpu_req_i = 1'b0;
        #1;
        chk("t4_last", bus.vrf_wdata_o, 64'hC5);
        tick();

        // Reset while both buffers are full and presented.
        drive_alu(1'b1, 3'd1, 16'h0600, 64'h50, 8'hFF);
        tick();
        bus.alu_req_i = 1'b0;
        tick();
        bus.vrf_gnt_i = 1'b0;
        drive_alu(1'b1, 3'd1, 16'h0600, 64'h51, 8'hFF);
        drive_mfpu(1'b1, 3'd2, 16'h0700, 64'h61, 8'hFF);
        tick();
        #1;
        chk("t5_pre_src", {bus.vrf_req_o, bus.vrf_src_o}, 2'b11);
        rst = 1'b1;
        #1;
        chk("t5_rst_req", {bus.vrf_req_o, bus.vrf_src_o}, 0);
        chk("t5_rst_payload", vrf_pl(), 0);
        chk("t5_rst_pending", {bus.alu_pending_o, bus.mfpu_pending_o}, 0);
        chk("t5_rst_gnts", {bus.alu_gnt_o, bus.mfpu_gnt_o}, 0);
        bus.alu_req_i = 1'b0; bus.mfpu_req_i = 1'b0;
        bus.vrf_gnt_i = 1'b1;
        @(negedge clk); rst = 1'b0;
        tick();
        #1;
        chk("t5_post_idle", bus.vrf_req_o, 0);
        bus.vrf_gnt_i = 1'b0;
        drive_alu(1'b1, 3'd1, 16'h0600, 64'h52, 8'hFF);
        drive_mfpu(1'b1, 3'd2, 16'h0700, 64'h62, 8'hFF);
        tick();
        bus.alu_req_i = 1'b0; bus.mfpu_req_i = 1'b0;
        #1;
        chk("t5_ptr_alu", {bus.vrf_src_o, bus.vrf_wdata_o}, {1'b0, 64'h52});
        chk("t5_pending", {bus.alu_pending_o, bus.mfpu_pending_o}, 2'b11);
        bus.vrf_gnt_i = 1'b1;
        tick();
        tick();
        #1;
        chk("t5_drained", bus.vrf_req_o, 0);

        // Random traffic against the scoreboard.
        qa.delete(); qm.delete();
        for (int c = 0; c < 3000; c++) rnd_cycle(1'b1);
        for (int c = 0; c < 10; c++) rnd_cycle(1'b0);
        chk("rnd_alu_left", qa.size(), 0);
        chk("rnd_mfpu_left", qm.size(), 0);
        chk("rnd_pending", {bus.alu_pending_o, bus.mfpu_pending_o}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
